// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: decode/execute/writeback register indices and
// status flags going into the hazard sequencer, and the stall/flush/forward
// controls coming back out to the pipeline registers and E-stage operand muxes.
interface hazard_ctrl_if #(
    parameter int RW = 5
);
    // Pipeline status toward the sequencer
    logic [5:0]    op_d;
    logic [RW-1:0] rs_d;
    logic [RW-1:0] rt_d;
    logic          ld_e;
    logic [RW-1:0] wreg_e;
    logic [RW-1:0] wreg_w;
    logic          br_taken_e;
    logic          mem_busy;

    // Controls back to the pipeline
    logic          hold_f;
    logic          hold_d;
    logic          bubble_e;
    logic          flush_d;
    logic [5:0]    op_bub;
    logic [1:0]    fwd_s;
    logic [1:0]    fwd_t;

    // Pipeline side: drives status, receives controls
    modport master (
        output op_d, rs_d, rt_d, ld_e, wreg_e, wreg_w, br_taken_e, mem_busy,
        input  hold_f, hold_d, bubble_e, flush_d, op_bub, fwd_s, fwd_t
    );

    // Sequencer side: receives status, drives controls
    modport slave (
        input  op_d, rs_d, rt_d, ld_e, wreg_e, wreg_w, br_taken_e, mem_busy,
        output hold_f, hold_d, bubble_e, flush_d, op_bub, fwd_s, fwd_t
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward sequencer for the 5-stage pipeline.
// Three-state controller (RUN / FLUSH / MEMWAIT) with a 4-bit flush counter that
// also holds the owed flush cycles across a memory stall, plus a pending-flush bit
// for branches that resolve while M is busy.
// Optional build macro HAZARD_CTRL_PERF_EN adds perf_stall / perf_flush counters.
module hazard_ctrl #(
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [5:0] NOP_OP       = 6'b110111,
    parameter int         RW           = 5
) (
    input  logic        clk,
    input  logic        rstd,
`ifdef HAZARD_CTRL_PERF_EN
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush,
`endif
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    // Full flush length, and the count left after the Mealy cycle in which the branch is seen
    localparam logic [3:0] FC_FULL   = 4'(FLUSH_CYCLES);
    localparam logic [3:0] FC_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam bit         FC_MULTI  = (FLUSH_CYCLES > 1);

    state_t     state_reg, state_next;
    logic [3:0] fcnt_reg, fcnt_next;
    logic       pend_reg, pend_next;

    logic       load_use;
    logic       hold_f_c, hold_d_c, bubble_c, flush_c;
    logic [3:0] fwd_all;

    // Load-use hazard: a load in E writing a register D reads; NOP in D never hazards
    assign load_use = hz.ld_e && (hz.wreg_e != '0)
                   && ((hz.wreg_e == hz.rs_d) || (hz.wreg_e == hz.rt_d))
                   && (hz.op_d != NOP_OP);

    // State register; reset drops any flush/stall in progress
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_reg <= RUN;
            fcnt_reg  <= '0;
            pend_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            fcnt_reg  <= fcnt_next;
            pend_reg  <= pend_next;
        end
    end

    // Next-state and control outputs; fcnt counts flush cycles still owed
    always_comb begin
        state_next = state_reg;
        fcnt_next  = fcnt_reg;
        pend_next  = pend_reg;
        hold_f_c   = 1'b0;
        hold_d_c   = 1'b0;
        bubble_c   = 1'b0;
        flush_c    = 1'b0;
        case (state_reg)
            RUN: begin
                if (hz.br_taken_e) begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FC_MULTI) begin
                        state_next = FLUSH;
                        fcnt_next  = FC_RELOAD;
                    end
                end else if (hz.mem_busy) begin
                    hold_f_c   = 1'b1;
                    hold_d_c   = 1'b1;
                    state_next = MEMWAIT;
                    fcnt_next  = '0;
                end else if (load_use) begin
                    hold_f_c = 1'b1;
                    bubble_c = 1'b1;
                end
            end
            FLUSH: begin
                if (hz.br_taken_e) begin
                    // A newer taken branch restarts the squash window
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (FC_MULTI) begin
                        fcnt_next = FC_RELOAD;
                    end else begin
                        state_next = RUN;
                        fcnt_next  = '0;
                    end
                end else if (hz.mem_busy) begin
                    // Freeze; the owed count stays in fcnt for resumption
                    hold_f_c   = 1'b1;
                    hold_d_c   = 1'b1;
                    state_next = MEMWAIT;
                end else begin
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (fcnt_reg <= 4'd1) begin
                        state_next = RUN;
                        fcnt_next  = '0;
                    end else begin
                        fcnt_next = fcnt_reg - 4'd1;
                    end
                end
            end
            MEMWAIT: begin
                if (hz.mem_busy) begin
                    hold_f_c = 1'b1;
                    hold_d_c = 1'b1;
                    if (hz.br_taken_e) begin
                        pend_next = 1'b1;
                    end
                end else begin
                    pend_next = 1'b0;
                    if (pend_reg || hz.br_taken_e) begin
                        state_next = FLUSH;
                        fcnt_next  = FC_FULL;
                    end else if (fcnt_reg != '0) begin
                        state_next = FLUSH;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = RUN;
                fcnt_next  = '0;
                pend_next  = 1'b0;
            end
        endcase
    end

    // Operand forwarding for s (gi=0) and t (gi=1); E result beats W result
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [RW-1:0] src_idx;
            logic [1:0]    sel;
            assign src_idx = (gi == 0) ? hz.rs_d : hz.rt_d;
            // Select the youngest in-flight producer of this source register
            always_comb begin
                sel = 2'b00;
                if ((hz.wreg_e != '0) && (hz.wreg_e == src_idx) && !hz.ld_e) begin
                    sel = 2'b01;
                end else if ((hz.wreg_w != '0) && (hz.wreg_w == src_idx)) begin
                    sel = 2'b10;
                end
            end
            assign fwd_all[gi*2 +: 2] = sel;
        end
    endgenerate

    // While reset is asserted the controls sit at their reset values immediately
    assign hz.hold_f   = rstd & hold_f_c;
    assign hz.hold_d   = rstd & hold_d_c;
    assign hz.flush_d  = rstd & flush_c;
    assign hz.bubble_e = ~rstd | bubble_c;
    assign hz.fwd_s    = rstd ? fwd_all[1:0] : 2'b00;
    assign hz.fwd_t    = rstd ? fwd_all[3:2] : 2'b00;
    assign hz.op_bub   = NOP_OP;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall_reg;
    logic [31:0] perf_flush_reg;

    // Count stalled and flushing cycles; free-running, wraps at 2^32
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            perf_stall_reg <= '0;
            perf_flush_reg <= '0;
        end else begin
            if (hz.hold_f) begin
                perf_stall_reg <= perf_stall_reg + 32'd1;
            end
            if (hz.flush_d) begin
                perf_flush_reg <= perf_flush_reg + 32'd1;
            end
        end
    end

    assign perf_stall = perf_stall_reg;
    assign perf_flush = perf_flush_reg;
`else
    // Counters are not built in this configuration
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus process drives one cycle at a time
// and pushes the reference model's expected controls; a monitor pops and compares
// on the falling edge.
module tb_hazard_ctrl;
    localparam int         FC  = 2;
    localparam logic [5:0] NOP = 6'b110111;

    typedef struct packed {
        logic        hold_f;
        logic        hold_d;
        logic        bubble_e;
        logic        flush_d;
        logic [1:0]  fwd_s;
        logic [1:0]  fwd_t;
        logic [31:0] ps;
        logic [31:0] pf;
    } exp_t;

    logic clk  = 1'b0;
    logic rstd = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    hazard_ctrl_if #(.RW(5)) hz ();

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] perf_stall, perf_flush;
    hazard_ctrl #(.FLUSH_CYCLES(FC), .NOP_OP(NOP), .RW(5)) dut (
        .clk(clk), .rstd(rstd), .perf_stall(perf_stall), .perf_flush(perf_flush), .hz(hz));
`else
    hazard_ctrl #(.FLUSH_CYCLES(FC), .NOP_OP(NOP), .RW(5)) dut (
        .clk(clk), .rstd(rstd), .hz(hz));
`endif

    always #5 clk = ~clk;

    // Reference model state: owed flush cycles, memory-wait flag, pending branch
    bit          m_wait = 0;
    bit          m_pend = 0;
    int          m_left = 0;
    logic [31:0] m_ps = 0;
    logic [31:0] m_pf = 0;

    function automatic logic [1:0] fwd_of(input logic [4:0] r, input bit ld,
                                          input logic [4:0] we, input logic [4:0] ww);
        if (r != 0 && r == we && !ld) return 2'b01;
        if (r != 0 && r == ww) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input bit r, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input bit ld, input logic [4:0] we,
                         input logic [4:0] ww, input bit br, input bit busy);
        exp_t e;
        bit   lu;
        @(posedge clk);
        #1;
        rstd = r;
        hz.op_d = op; hz.rs_d = rs; hz.rt_d = rt; hz.ld_e = ld;
        hz.wreg_e = we; hz.wreg_w = ww; hz.br_taken_e = br; hz.mem_busy = busy;
        e = '0;
        if (!r) begin
            m_wait = 0; m_pend = 0; m_left = 0; m_ps = 0; m_pf = 0;
            e.bubble_e = 1'b1;
        end else begin
            e.ps = m_ps;
            e.pf = m_pf;
            e.fwd_s = fwd_of(rs, ld, we, ww);
            e.fwd_t = fwd_of(rt, ld, we, ww);
            lu = ld && we != 0 && (we == rs || we == rt) && op != NOP;
            if (!m_wait) begin
                if (br) begin
                    e.flush_d = 1; e.bubble_e = 1; m_left = FC - 1;
                end else if (busy) begin
                    e.hold_f = 1; e.hold_d = 1; m_wait = 1;
                end else if (m_left > 0) begin
                    e.flush_d = 1; e.bubble_e = 1; m_left--;
                end else if (lu) begin
                    e.hold_f = 1; e.bubble_e = 1;
                end
            end else if (busy) begin
                e.hold_f = 1; e.hold_d = 1;
                if (br) m_pend = 1;
            end else begin
                m_wait = 0;
                if (m_pend || br) m_left = FC;
                m_pend = 0;
            end
            m_ps = m_ps + 32'(e.hold_f);
            m_pf = m_pf + 32'(e.flush_d);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endfunction

    // Monitor: one compared transaction per cycle the DUT output is valid
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hold_f",   32'(hz.hold_f),   32'(e.hold_f));
                chk("hold_d",   32'(hz.hold_d),   32'(e.hold_d));
                chk("bubble_e", 32'(hz.bubble_e), 32'(e.bubble_e));
                chk("flush_d",  32'(hz.flush_d),  32'(e.flush_d));
                chk("fwd_s",    32'(hz.fwd_s),    32'(e.fwd_s));
                chk("fwd_t",    32'(hz.fwd_t),    32'(e.fwd_t));
                chk("op_bub",   32'(hz.op_bub),   32'(NOP));
`ifdef HAZARD_CTRL_PERF_EN
                chk("perf_stall", perf_stall, e.ps);
                chk("perf_flush", perf_flush, e.pf);
`endif
                $display("[TB] t=%0t hf=%0b hd=%0b bub=%0b fl=%0b fs=%0d ft=%0d",
                         $time, hz.hold_f, hz.hold_d, hz.bubble_e, hz.flush_d, hz.fwd_s, hz.fwd_t);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        hz.op_d = '0; hz.rs_d = '0; hz.rt_d = '0; hz.ld_e = 0;
        hz.wreg_e = '0; hz.wreg_w = '0; hz.br_taken_e = 0; hz.mem_busy = 0;
        apply(0, 6'd0, 5'd3, 5'd3, 1, 5'd3, 5'd3, 1, 1);   // reset values under busy inputs
        apply(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        idle(1);
        // load-use then W forwarding of the loaded value
        apply(1, 6'd0, 5'd5, 5'd0, 1, 5'd5, 5'd0, 0, 0);
        apply(1, 6'd0, 5'd5, 5'd0, 0, 5'd0, 5'd5, 0, 0);
        // NOP in D never hazards
        apply(1, NOP,  5'd5, 5'd0, 1, 5'd5, 5'd0, 0, 0);
        // taken branch: two flush cycles then RUN
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 1, 0);
        idle(3);
        // mem_busy 3 cycles with branch in the 2nd
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 1, 1);
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
        idle(4);
        // forwarding E over W, and register 0
        apply(1, 6'd0, 5'd3, 5'd7, 0, 5'd7, 5'd7, 0, 0);
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        // busy in the middle of a flush preserves the owed cycle
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 1, 0);
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 1);
        idle(3);
        // reset during flush cycle 1, no flush after release
        apply(1, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 1, 0);
        apply(0, 6'd0, 5'd0, 5'd0, 0, 5'd0, 5'd0, 0, 0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            apply(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 5) == 0) ? NOP : 6'($urandom),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(1);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
